// File: rtl/orv64_div.sv
// orv64_div - iterative radix-2 restoring integer divider for the ORV64 execute stage.
// Implements DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW with RISC-V divide-by-zero
// and signed-overflow results. Operands are converted to magnitudes on accept, N
// restoring iterations produce quotient and remainder, and a fix-up cycle restores
// signs and selects the result.
//
// Optional feature: define ORV64_DIV_FAST_SPECIAL_EN to finish divide-by-zero,
// signed overflow and |dividend| < |divisor| directly on accept (complete at T+1).
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   start_pulse  request, accepted only when idle and not killed
//   kill         flush, aborts any operation without a complete
//   rs1, rs2     dividend, divisor (only sampled in the accept cycle)
//   is_signed    signed operation
//   is_rem       return remainder instead of quotient
//   is_word      32-bit W form, result sign-extended from bit 31
//   rd           result, held until the next complete
//   complete     one-cycle pulse, rd valid
//   busy         operation in progress (state != IDLE)
module orv64_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_pulse,
  input  logic            kill,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  output logic [XLEN-1:0] rd,
  output logic            complete,
  output logic            busy
);

  localparam int HX = XLEN / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_div;
  logic [6:0]        r_cnt;
  logic              r_word;
  logic              r_is_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_rd;

  // Operand preparation (accept cycle): W forms extend bit HX-1 first.
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_accept;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;

  assign w_a = is_word ? {{HX{is_signed & rs1[HX-1]}}, rs1[HX-1:0]} : rs1;
  assign w_b = is_word ? {{HX{is_signed & rs2[HX-1]}}, rs2[HX-1:0]} : rs2;
  assign w_a_neg = is_signed & w_a[XLEN-1];
  assign w_b_neg = is_signed & w_b[XLEN-1];
  assign w_a_mag = w_a_neg ? (~w_a + {{(XLEN-1){1'b0}}, 1'b1}) : w_a;
  assign w_b_mag = w_b_neg ? (~w_b + {{(XLEN-1){1'b0}}, 1'b1}) : w_b;
  assign w_accept = start_pulse & ~kill;

`ifdef ORV64_DIV_FAST_SPECIAL_EN
  logic            w_dz;
  logic            w_ovf;
  logic            w_small;
  logic [XLEN-1:0] w_fast_raw;

  assign w_dz    = (w_b == {XLEN{1'b0}});
  assign w_ovf   = is_signed & (w_b == {XLEN{1'b1}}) &
                   (is_word ? (w_a[HX-1:0] == {1'b1, {(HX-1){1'b0}}})
                            : (w_a == {1'b1, {(XLEN-1){1'b0}}}));
  assign w_small = (w_a_mag < w_b_mag);
  assign w_fast  = w_dz | w_ovf | w_small;

  // Fast-path result: dz -> q=-1,r=a; ovf -> q=a,r=0; small -> q=0,r=a.
  always_comb begin
    w_fast_raw = {XLEN{1'b0}};
    if (w_dz) begin
      w_fast_raw = is_rem ? w_a : {XLEN{1'b1}};
    end else if (w_ovf) begin
      w_fast_raw = is_rem ? {XLEN{1'b0}} : w_a;
    end else begin
      w_fast_raw = is_rem ? w_a : {XLEN{1'b0}};
    end
  end
  assign w_fast_res = is_word ? {{HX{w_fast_raw[HX-1]}}, w_fast_raw[HX-1:0]} : w_fast_raw;
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = {XLEN{1'b0}};
`endif

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_last;
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_last  = (r_cnt == (r_word ? 7'(HX - 1) : 7'(XLEN - 1)));

  // Sign fix-up and result selection; a zero divisor leaves q = all ones of N bits.
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_sel;
  logic [XLEN-1:0]   w_res;
  assign w_q   = r_neg_q ? (~r_quo + {{(XLEN-1){1'b0}}, 1'b1}) : r_quo;
  assign w_r   = r_neg_r ? (~r_rem + {{(XLEN-1){1'b0}}, 1'b1}) : r_rem;
  assign w_sel = r_is_rem ? w_r : w_q;
  assign w_res = r_word ? {{HX{w_sel[HX-1]}}, w_sel[HX-1:0]} : w_sel;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; kill returns to IDLE from any state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_fast ? DONE : ITER;
        end else begin
          w_next = IDLE;
        end
      end
      ITER: begin
        if (kill) begin
          w_next = IDLE;
        end else if (w_last) begin
          w_next = FIX;
        end else begin
          w_next = ITER;
        end
      end
      FIX: begin
        if (kill) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    complete = 1'b0;
    busy     = 1'b1;
    case (r_state)
      IDLE:    busy = 1'b0;
      DONE:    complete = 1'b1;
      default: begin
        complete = 1'b0;
        busy     = 1'b1;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem    <= {XLEN{1'b0}};
      r_quo    <= {XLEN{1'b0}};
      r_div    <= {XLEN{1'b0}};
      r_cnt    <= 7'd0;
      r_word   <= 1'b0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rd     <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem    <= {XLEN{1'b0}};
            // W forms: dividend placed in the top half so its msb leads the shift.
            r_quo    <= is_word ? {w_a_mag[HX-1:0], {HX{1'b0}}} : w_a_mag;
            r_div    <= w_b_mag;
            r_cnt    <= 7'd0;
            r_word   <= is_word;
            r_is_rem <= is_rem;
            // Zero divisor keeps the all-ones quotient unsigned.
            r_neg_q  <= (w_a_neg ^ w_b_neg) & (w_b != {XLEN{1'b0}});
            r_neg_r  <= w_a_neg;
            if (w_fast) begin
              r_rd <= w_fast_res;
            end
          end
        end
        ITER: begin
          r_cnt <= r_cnt + 7'd1;
          if (!w_diff[XLEN]) begin
            r_rem <= w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
          end
        end
        FIX: begin
          if (!kill) begin
            r_rd <= w_res;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign rd = r_rd;

endmodule

// File: tb/tb_orv64_div.sv
// Directed self-checking bench for orv64_div: arithmetic results, latency,
// busy handshake, kill and mid-operation reset.
module tb_orv64_div;

  logic        clk;
  logic        rst_n;
  logic        start_pulse;
  logic        kill;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        is_signed;
  logic        is_rem;
  logic        is_word;
  logic [63:0] rd;
  logic        complete;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef ORV64_DIV_FAST_SPECIAL_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 0;
`endif

  orv64_div #(.XLEN(64)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_pulse (start_pulse),
    .kill        (kill),
    .rs1         (rs1),
    .rs2         (rs2),
    .is_signed   (is_signed),
    .is_rem      (is_rem),
    .is_word     (is_word),
    .rd          (rd),
    .complete    (complete),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // Issue one operation and wait for complete; lat counts edges from accept.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic r, input logic w,
                        output logic [63:0] res, output int lat);
    @(negedge clk);
    rs1 = a; rs2 = b; is_signed = s; is_rem = r; is_word = w; start_pulse = 1'b1;
    @(posedge clk); #1;
    start_pulse = 1'b0;
    rs1 = 64'hDEAD_BEEF_DEAD_BEEF; rs2 = 64'h0123_4567_89AB_CDEF;
    lat = 1;
    while (!complete && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!complete) lat = 999;
    res = rd;
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       tag;
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        r;
    logic        w;
    logic [63:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [63:0] res;
    int          lat;
    int          ncomp;
    int          exp_lat;

    rst_n = 1'b0; start_pulse = 1'b0; kill = 1'b0;
    rs1 = 64'd0; rs2 = 64'd0; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd", rd, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_complete", {63'd0, complete}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{"div_m20_3",    64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0});
    vecs.push_back('{"rem_m20_3",    64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{"divu_max_2",   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{"remu_max_2",   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b1, 1'b0, 64'd1, 1'b0});
    vecs.push_back('{"div_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1});
    vecs.push_back('{"rem_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1});
    vecs.push_back('{"divw_ovf",     64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1});
    vecs.push_back('{"divu_dz",      64'd7, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{"remuw_dz",     64'h0000_0001_8000_0005, 64'd0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0005, 1'b1});
    vecs.push_back('{"div_dz_neg",   64'hFFFF_FFFF_FFFF_FFF6, 64'd0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{"divw_100_7",   64'd100, 64'd7, 1'b1, 1'b0, 1'b1, 64'd14, 1'b0});
    vecs.push_back('{"remw_m7_2",    64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{"divuw_ff_1",   64'h1234_5678_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{"div_5_7",      64'd5, 64'd7, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1});
    vecs.push_back('{"rem_5_m7",     64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b1, 1'b0, 64'd5, 1'b1});
    vecs.push_back('{"div_m100_m9",  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF7, 1'b1, 1'b0, 1'b0, 64'd11, 1'b0});

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].w, res, lat);
      chk(vecs[i].tag, res, vecs[i].exp);
      if (vecs[i].special && LAT_SPECIAL != 0) exp_lat = 1;
      else exp_lat = vecs[i].w ? 34 : 66;
      chk({vecs[i].tag, "_lat"}, 64'(lat), 64'(exp_lat));
    end

    // start_pulse while busy is ignored: exactly one complete, first operands win.
    @(negedge clk);
    rs1 = 64'd100; rs2 = 64'd7; is_signed = 1'b1; is_rem = 1'b0; is_word = 1'b1; start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    ncomp = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 3 || c == 10 || c == 20) begin
        rs1 = 64'd999; rs2 = 64'd3; start_pulse = 1'b1;
      end else begin
        start_pulse = 1'b0;
      end
      if (complete) ncomp++;
    end
    start_pulse = 1'b0;
    chk("busy_ignore_ncomp", 64'(ncomp), 64'd1);
    chk("busy_ignore_rd", rd, 64'd14);

    // kill 10 cycles into a DIV: idle next cycle, no complete, rd held.
    @(negedge clk);
    rs1 = 64'd1000; rs2 = 64'd3; is_signed = 1'b1; is_rem = 1'b0; is_word = 1'b0; start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    repeat (9) @(negedge clk);
    chk("kill_busy_before", {63'd0, busy}, 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy_after", {63'd0, busy}, 64'd0);
    ncomp = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (complete) ncomp++;
    end
    chk("kill_ncomp", 64'(ncomp), 64'd0);
    chk("kill_rd_held", rd, 64'd14);

    // kill together with start in IDLE is not accepted.
    @(negedge clk);
    start_pulse = 1'b1; kill = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0; kill = 1'b0;
    chk("kill_start_busy", {63'd0, busy}, 64'd0);

    // reset mid-ITER clears rd and returns to idle with no complete.
    @(negedge clk);
    rs1 = 64'd1000; rs2 = 64'd3; is_signed = 1'b0; start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_rd", rd, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    ncomp = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (complete) ncomp++;
    end
    chk("rst_mid_ncomp", 64'(ncomp), 64'd0);

    // divider still works after the reset.
    run_op(64'd1000, 64'd3, 1'b0, 1'b1, 1'b0, res, lat);
    chk("post_rst_remu", res, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
